// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_defs_pkg : shared ISA encodings, pipeline constants and helper functions
// Rev 1.0
// ---------------------------------------------------------------------------
package cpu_defs_pkg;

   localparam int CPU_DATA_W = 16;
   localparam int CPU_IR_W   = 16;

   typedef enum logic [4:0] {
      OP_NOP   = 5'b00000,
      OP_HALT  = 5'b00001,
      OP_LOAD  = 5'b00010,
      OP_STORE = 5'b00011,
      OP_SLL   = 5'b00100,
      OP_SLA   = 5'b00101,
      OP_SRL   = 5'b00110,
      OP_SRA   = 5'b00111,
      OP_ADD   = 5'b01000,
      OP_ADDI  = 5'b01001,
      OP_SUB   = 5'b01010,
      OP_SUBI  = 5'b01011,
      OP_CMP   = 5'b01100,
      OP_AND   = 5'b01101,
      OP_OR    = 5'b01110,
      OP_XOR   = 5'b01111,
      OP_LDIH  = 5'b10000,
      OP_ADDC  = 5'b10001,
      OP_SUBC  = 5'b10010,
      OP_JUMP  = 5'b11000,
      OP_JMPR  = 5'b11001,
      OP_BZ    = 5'b11010,
      OP_BNZ   = 5'b11011,
      OP_BN    = 5'b11100,
      OP_BNN   = 5'b11101,
      OP_BC    = 5'b11110,
      OP_BNC   = 5'b11111
   } opcode_e;

   typedef enum logic [2:0] {
      BSEL_ZERO = 3'd0,
      BSEL_REG  = 3'd1,
      BSEL_IMM4 = 3'd2,
      BSEL_IMM8 = 3'd3,
      BSEL_HI8  = 3'd4
   } bsel_e;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_EXEC = 1'b1;

   localparam logic [2:0] GR0 = 3'd0;
   localparam logic [2:0] GR1 = 3'd1;
   localparam logic [2:0] GR2 = 3'd2;
   localparam logic [2:0] GR3 = 3'd3;
   localparam logic [2:0] GR4 = 3'd4;
   localparam logic [2:0] GR5 = 3'd5;
   localparam logic [2:0] GR6 = 3'd6;
   localparam logic [2:0] GR7 = 3'd7;

   // Opcodes that retire a result into gr[ir[10:8]].
   function automatic logic writes_reg(input logic [4:0] op);
      logic r;
      case (op)
         OP_LOAD, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_AND, OP_OR, OP_XOR,
         OP_SLL, OP_SLA, OP_SRL, OP_SRA, OP_LDIH, OP_ADDC, OP_SUBC: r = 1'b1;
         default:                                                   r = 1'b0;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fwd_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// operand_fwd_sel : one operand source, EX > MEM > WB > gr priority plus hazard hits
// Build option OPFETCH_FWD_EN enables the bypass paths. Rev 1.0
// ---------------------------------------------------------------------------
module operand_fwd_sel
   import cpu_defs_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int IR_W   = CPU_IR_W
) (
   input  logic [2:0]        i_src,
   input  logic              i_use,
   input  logic [DATA_W-1:0] i_gr,
   input  logic [IR_W-1:0]   i_ex_ir,
   input  logic [DATA_W-1:0] i_ex_res,
   input  logic [IR_W-1:0]   i_mem_ir,
   input  logic [DATA_W-1:0] i_mem_res,
   input  logic [IR_W-1:0]   i_wb_ir,
   input  logic [DATA_W-1:0] i_wb_res,
   output logic [DATA_W-1:0] o_data,
   output logic              o_hit_ex_load,
   output logic              o_hit_any
);

   logic w_m_ex;
   logic w_m_mem;
   logic w_m_wb;

   assign w_m_ex  = i_use && writes_reg(i_ex_ir[15:11])  && (i_ex_ir[10:8]  == i_src);
   assign w_m_mem = i_use && writes_reg(i_mem_ir[15:11]) && (i_mem_ir[10:8] == i_src);
   assign w_m_wb  = i_use && writes_reg(i_wb_ir[15:11])  && (i_wb_ir[10:8]  == i_src);

   assign o_hit_ex_load = w_m_ex && (i_ex_ir[15:11] == OP_LOAD);
   assign o_hit_any     = w_m_ex || w_m_mem || w_m_wb;

`ifdef OPFETCH_FWD_EN
   always_comb begin
      o_data = i_gr;
      if (w_m_ex)
         o_data = i_ex_res;
      else if (w_m_mem)
         o_data = i_mem_res;
      else if (w_m_wb)
         o_data = i_wb_res;
   end

   logic w_unused;
   assign w_unused = ^{i_ex_ir[7:0], i_mem_ir[7:0], i_wb_ir[7:0]};
`else
   assign o_data = i_gr;

   logic w_unused;
   assign w_unused = ^{i_ex_ir[7:0], i_mem_ir[7:0], i_wb_ir[7:0],
                       i_ex_res, i_mem_res, i_wb_res};
`endif

endmodule
`default_nettype wire

// File: rtl/id_operand_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// id_operand_fetch : ID-stage decode, operand read/forward, hazard stall, ID/EX register
// Build option OPFETCH_FWD_EN: bypass network; otherwise stall until writers retire. Rev 1.0
// ---------------------------------------------------------------------------
module id_operand_fetch
   import cpu_defs_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int IR_W   = CPU_IR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              state,
   input  logic [IR_W-1:0]   id_ir,
   input  logic [DATA_W-1:0] gr0,
   input  logic [DATA_W-1:0] gr1,
   input  logic [DATA_W-1:0] gr2,
   input  logic [DATA_W-1:0] gr3,
   input  logic [DATA_W-1:0] gr4,
   input  logic [DATA_W-1:0] gr5,
   input  logic [DATA_W-1:0] gr6,
   input  logic [DATA_W-1:0] gr7,
   output logic [IR_W-1:0]   ex_ir_q,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [IR_W-1:0]   mem_ir,
   input  logic [DATA_W-1:0] mem_res,
   input  logic [IR_W-1:0]   wb_ir,
   input  logic [DATA_W-1:0] reg_C1,
   input  logic              flush,
   output logic [DATA_W-1:0] reg_A,
   output logic [DATA_W-1:0] reg_B,
   output logic [DATA_W-1:0] smdr,
   output logic              stall,
   output logic [15:0]       stall_cnt
);

   logic [IR_W-1:0]   r_ex_ir;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] r_smdr;
   logic [15:0]       r_stall_cnt;

   logic [DATA_W-1:0] w_gr [0:7];
   opcode_e           w_op;
   logic [2:0]        w_r1;
   logic [2:0]        w_r2;
   logic [2:0]        w_r3;
   logic [7:0]        w_val8;

   logic [2:0]        w_src_a;
   logic              w_use_a;
   logic              w_use_b;
   logic              w_use_s;
   bsel_e             w_bsel;

   logic [DATA_W-1:0] w_fwd_a;
   logic [DATA_W-1:0] w_fwd_b;
   logic [DATA_W-1:0] w_fwd_s;
   logic [DATA_W-1:0] w_b_val;
   logic [DATA_W-1:0] w_s_val;
   logic              w_ld_a;
   logic              w_ld_b;
   logic              w_ld_s;
   logic              w_any_a;
   logic              w_any_b;
   logic              w_any_s;
   logic              w_hazard;

   assign w_gr[0] = gr0;
   assign w_gr[1] = gr1;
   assign w_gr[2] = gr2;
   assign w_gr[3] = gr3;
   assign w_gr[4] = gr4;
   assign w_gr[5] = gr5;
   assign w_gr[6] = gr6;
   assign w_gr[7] = gr7;

   assign w_op   = opcode_e'(id_ir[15:11]);
   assign w_r1   = id_ir[10:8];
   assign w_r2   = id_ir[6:4];
   assign w_r3   = id_ir[2:0];
   assign w_val8 = id_ir[7:0];

   always_comb begin
      w_src_a = w_r2;
      w_use_a = 1'b1;
      w_use_b = 1'b0;
      w_use_s = 1'b0;
      w_bsel  = BSEL_ZERO;
      case (w_op)
         OP_NOP, OP_HALT: w_use_a = 1'b0;
         OP_ADDI, OP_SUBI, OP_JUMP, OP_JMPR,
         OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: begin
            w_src_a = w_r1;
            w_bsel  = BSEL_IMM8;
         end
         OP_LDIH: begin
            w_src_a = w_r1;
            w_bsel  = BSEL_HI8;
         end
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP, OP_ADDC, OP_SUBC: begin
            w_use_b = 1'b1;
            w_bsel  = BSEL_REG;
         end
         OP_LOAD, OP_SLL, OP_SLA, OP_SRL, OP_SRA: w_bsel = BSEL_IMM4;
         OP_STORE: begin
            w_use_s = 1'b1;
            w_bsel  = BSEL_IMM4;
         end
         default: w_use_a = 1'b0;
      endcase
   end

   operand_fwd_sel #(.DATA_W(DATA_W), .IR_W(IR_W)) u_sel_a (
      .i_src         (w_src_a),
      .i_use         (w_use_a),
      .i_gr          (w_gr[w_src_a]),
      .i_ex_ir       (r_ex_ir),
      .i_ex_res      (alu_out),
      .i_mem_ir      (mem_ir),
      .i_mem_res     (mem_res),
      .i_wb_ir       (wb_ir),
      .i_wb_res      (reg_C1),
      .o_data        (w_fwd_a),
      .o_hit_ex_load (w_ld_a),
      .o_hit_any     (w_any_a)
   );

   operand_fwd_sel #(.DATA_W(DATA_W), .IR_W(IR_W)) u_sel_b (
      .i_src         (w_r3),
      .i_use         (w_use_b),
      .i_gr          (w_gr[w_r3]),
      .i_ex_ir       (r_ex_ir),
      .i_ex_res      (alu_out),
      .i_mem_ir      (mem_ir),
      .i_mem_res     (mem_res),
      .i_wb_ir       (wb_ir),
      .i_wb_res      (reg_C1),
      .o_data        (w_fwd_b),
      .o_hit_ex_load (w_ld_b),
      .o_hit_any     (w_any_b)
   );

   operand_fwd_sel #(.DATA_W(DATA_W), .IR_W(IR_W)) u_sel_s (
      .i_src         (w_r1),
      .i_use         (w_use_s),
      .i_gr          (w_gr[w_r1]),
      .i_ex_ir       (r_ex_ir),
      .i_ex_res      (alu_out),
      .i_mem_ir      (mem_ir),
      .i_mem_res     (mem_res),
      .i_wb_ir       (wb_ir),
      .i_wb_res      (reg_C1),
      .o_data        (w_fwd_s),
      .o_hit_ex_load (w_ld_s),
      .o_hit_any     (w_any_s)
   );

   always_comb begin
      case (w_bsel)
         BSEL_REG:  w_b_val = w_fwd_b;
         BSEL_IMM4: w_b_val = {{(DATA_W-4){1'b0}}, w_val8[3:0]};
         BSEL_IMM8: w_b_val = {{(DATA_W-8){1'b0}}, w_val8};
         BSEL_HI8:  w_b_val = {w_val8, {(DATA_W-8){1'b0}}};
         default:   w_b_val = '0;
      endcase
   end

   assign w_s_val = w_use_s ? w_fwd_s : '0;

`ifdef OPFETCH_FWD_EN
   // Only a load in EX cannot be bypassed; everything else is forwarded.
   assign w_hazard = w_ld_a || w_ld_b || w_ld_s;
`else
   assign w_hazard = w_any_a || w_any_b || w_any_s;
`endif

   logic w_unused;
   assign w_unused = ^{w_ld_a, w_ld_b, w_ld_s, w_any_a, w_any_b, w_any_s};

   assign stall = (state == ST_EXEC) && !flush && w_hazard;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ex_ir     <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_smdr      <= '0;
         r_stall_cnt <= '0;
      end else if (state == ST_EXEC) begin
         if (flush || stall) begin
            r_ex_ir <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_smdr  <= '0;
         end else begin
            r_ex_ir <= id_ir;
            r_a     <= w_fwd_a;
            r_b     <= w_b_val;
            r_smdr  <= w_s_val;
         end
         if (stall && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign ex_ir_q   = r_ex_ir;
   assign reg_A     = r_a;
   assign reg_B     = r_b;
   assign smdr      = r_smdr;
   assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
